gray_rx_decoder: RTL and testbench
==================================

Name: gray_rx_decoder

Overview:
Destination-domain stage directly downstream of the 2-flop Gray-code synchronizer. It takes the already-synchronized Gray word, converts it to binary and emits a one-cycle update pulse with the signed step (modulo 2^WIDTH) on every legal single-bit transition. It flags illegal multi-bit transitions, which indicate source-side mis-encoding or a sampling fault, and counts them. Single clock domain (the destination clock).

Parameters:
WIDTH, 2, width of Gray/binary words; must be >= 2
ERR_CNT_W, 8, width of saturating illegal-transition counter

Ports:
clk  input  1  destination-domain clock, rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  sample enable; when 0 the block holds state
gray_in  input  WIDTH  synchronized Gray code from the synchronizer output
bin_out  output  WIDTH  binary value of last accepted Gray word
delta  output  WIDTH  (new_bin - old_bin) mod 2^WIDTH of last legal update
upd  output  1  one-cycle pulse: legal transition accepted
err  output  1  one-cycle pulse: illegal transition (Hamming distance > 1)
err_cnt  output  ERR_CNT_W  saturating count of illegal transitions
primed  output  1  first sample after reset has been captured

Behaviour:
- Reset (async, immediate on rst=1): bin_out=0, delta=0, upd=0, err=0, err_cnt=0, primed=0, internal g_prev=0.
- g2b: b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1]^g[i]. Combinational on gray_in. All outputs are registered, so results appear one clk after the sampling edge.
- upd and err are pulses. They default to 0 every cycle unless set by the rules below.
- en=0: no state change; upd=err=0.
- en=1, primed=0 (priming): g_prev<=gray_in, bin_out<=g2b(gray_in), primed<=1. No upd, no err, delta unchanged.
- en=1, primed=1, gray_in==g_prev: no change.
- en=1, primed=1, popcount(gray_in^g_prev)==1 (legal):
  - upd<=1, bin_out<=g2b(gray_in), g_prev<=gray_in.
  - delta<=g2b(gray_in)-g2b(g_prev), truncated to WIDTH bits. Forward step = 1; backward step = 2^WIDTH-1.
- en=1, primed=1, popcount>1 (illegal):
  - err<=1, err_cnt<=err_cnt+1, saturating at 2^ERR_CNT_W-1 with no wrap.
  - Resynchronize: g_prev<=gray_in, bin_out<=g2b(gray_in).
  - upd=0, delta unchanged.
- Wrap-around (max binary -> 0) is a legal single-bit Gray change; delta=1.
- gray_in is assumed already synchronized; the block adds no metastability flops.
- rst asserted mid-stream: all state clears immediately. After release, the next en cycle re-primes with no spurious upd/err.
- upd and err are never asserted in the same cycle.

Test Plan:
(All with WIDTH=2. Gray 00,01,11,10 = binary 0,1,2,3.)
- Priming: rst=1 then 0 with gray_in=01, en=1 -> one cycle later bin_out=1, primed=1, upd=0, err=0, delta=0.
- Forward count 01->11->10->00, each held 2 clk -> upd pulses once per change; bin_out 2,3,0; delta=1 every time, including the 3->0 wrap.
- Backward step 00->10 -> upd=1, bin_out=3, delta=3.
- Illegal 00->11 -> err=1 for one cycle, upd=0, err_cnt=1, bin_out=2, delta held. Then 11->01 is legal: upd=1, bin_out=1, delta=3. With ERR_CNT_W=2, five illegal jumps -> err_cnt stops at 3.
- Enable gating: en=0 while gray_in goes 01->11->10 -> no pulses, bin_out held at 1. Then en=1 with gray_in=10 -> compared against g_prev=01, popcount 2 -> err=1, bin_out=3.
- Async reset mid-operation: rst pulsed between clk edges while bin_out=2, err_cnt=1 -> all outputs 0 immediately, without waiting for a clk edge. The first en cycle after release primes with no upd/err.

Source files
------------

// File: rtl/gray_rx_decoder_if.sv
// Handshake-free sample bus between the Gray synchronizer and its decoder.
// The driver presents the sample and enable; the decoder returns the decoded state and pulses.
interface gray_rx_decoder_if #(
  parameter int unsigned WIDTH     = 2,
  parameter int unsigned ERR_CNT_W = 8
);
  logic                 en;
  logic [WIDTH-1:0]     gray_in;
  logic [WIDTH-1:0]     bin_out;
  logic [WIDTH-1:0]     delta;
  logic                 upd;
  logic                 err;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic                 primed;

  modport master (
    output en, gray_in,
    input  bin_out, delta, upd, err, err_cnt, primed
  );

  modport slave (
    input  en, gray_in,
    output bin_out, delta, upd, err, err_cnt, primed
  );
endinterface

// File: rtl/gray_rx_decoder.sv
// Destination-side Gray decoder: converts the synchronized Gray word to binary, reports the
// signed step on legal single-bit changes and flags/counts illegal multi-bit jumps.
module gray_rx_decoder #(
  parameter int unsigned WIDTH     = 2,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  gray_rx_decoder_if.slave   bus
);

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [0:0] {
    ST_UNPRIMED = 1'b0,
    ST_ACTIVE   = 1'b1
  } state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     g_prev, g_prev_nxt;
  logic [WIDTH-1:0]     bin_q, bin_nxt;
  logic [WIDTH-1:0]     delta_q, delta_nxt;
  logic                 upd_q, upd_nxt;
  logic                 err_q, err_nxt;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_nxt;

  logic [WIDTH-1:0]     bin_in_c;
  logic [WIDTH-1:0]     bin_prev_c;
  logic [WIDTH-1:0]     diff_c;
  logic                 one_bit_c;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign bin_in_c   = g2b(bus.gray_in);
  assign bin_prev_c = g2b(g_prev);
  assign diff_c     = bus.gray_in ^ g_prev;
  // Nonzero with a single set bit means Hamming distance exactly one.
  assign one_bit_c  = (diff_c != '0) && ((diff_c & (diff_c - WIDTH'(1))) == '0);

  always_comb begin
    state_nxt  = state;
    g_prev_nxt = g_prev;
    bin_nxt    = bin_q;
    delta_nxt  = delta_q;
    cnt_nxt    = cnt_q;
    upd_nxt    = 1'b0;
    err_nxt    = 1'b0;
    if (bus.en) begin
      case (state)
        ST_UNPRIMED: begin
          g_prev_nxt = bus.gray_in;
          bin_nxt    = bin_in_c;
          state_nxt  = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (one_bit_c) begin
            upd_nxt    = 1'b1;
            g_prev_nxt = bus.gray_in;
            bin_nxt    = bin_in_c;
            delta_nxt  = WIDTH'(bin_in_c - bin_prev_c);
          end else if (diff_c != '0) begin
            // Illegal jump: flag it and resynchronize to the new word.
            err_nxt    = 1'b1;
            g_prev_nxt = bus.gray_in;
            bin_nxt    = bin_in_c;
            if (cnt_q != CNT_MAX) begin
              cnt_nxt = cnt_q + ERR_CNT_W'(1);
            end
          end
        end
        default: state_nxt = ST_UNPRIMED;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_UNPRIMED;
      g_prev  <= '0;
      bin_q   <= '0;
      delta_q <= '0;
      cnt_q   <= '0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      g_prev  <= g_prev_nxt;
      bin_q   <= bin_nxt;
      delta_q <= delta_nxt;
      cnt_q   <= cnt_nxt;
      upd_q   <= upd_nxt;
      err_q   <= err_nxt;
    end
  end

  assign bus.bin_out = bin_q;
  assign bus.delta   = delta_q;
  assign bus.upd     = upd_q;
  assign bus.err     = err_q;
  assign bus.err_cnt = cnt_q;
  assign bus.primed  = (state == ST_ACTIVE);

endmodule

// File: tb/tb_gray_rx_decoder.sv
// Directed bench for gray_rx_decoder at WIDTH=2, ERR_CNT_W=2 (Gray 00,01,11,10 = 0,1,2,3).
module tb_gray_rx_decoder;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  gray_rx_decoder_if #(.WIDTH(2), .ERR_CNT_W(2)) bus ();

  gray_rx_decoder #(.WIDTH(2), .ERR_CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [1:0] g;
    logic [1:0] bin;
    logic [1:0] dlt;
    logic       upd;
    logic       err;
    logic [1:0] cnt;
    logic       primed;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] bin, input logic [1:0] dlt,
                           input logic upd, input logic err, input logic [1:0] cnt,
                           input logic primed);
    check({tag, " bin_out"}, 32'(bus.bin_out), 32'(bin));
    check({tag, " delta"},   32'(bus.delta),   32'(dlt));
    check({tag, " upd"},     32'(bus.upd),     32'(upd));
    check({tag, " err"},     32'(bus.err),     32'(err));
    check({tag, " err_cnt"}, 32'(bus.err_cnt), 32'(cnt));
    check({tag, " primed"},  32'(bus.primed),  32'(primed));
  endtask

  task automatic step(input logic en, input logic [1:0] g);
    @(negedge clk);
    bus.en      = en;
    bus.gray_in = g;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    //           en  g      bin    delta  upd  err  cnt    primed
    vecs[0]  = '{1'b1, 2'b01, 2'd1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1}; // prime
    vecs[1]  = '{1'b1, 2'b01, 2'd1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1}; // hold
    vecs[2]  = '{1'b1, 2'b11, 2'd2, 2'd1, 1'b1, 1'b0, 2'd0, 1'b1};
    vecs[3]  = '{1'b1, 2'b11, 2'd2, 2'd1, 1'b0, 1'b0, 2'd0, 1'b1};
    vecs[4]  = '{1'b1, 2'b10, 2'd3, 2'd1, 1'b1, 1'b0, 2'd0, 1'b1};
    vecs[5]  = '{1'b1, 2'b10, 2'd3, 2'd1, 1'b0, 1'b0, 2'd0, 1'b1};
    vecs[6]  = '{1'b1, 2'b00, 2'd0, 2'd1, 1'b1, 1'b0, 2'd0, 1'b1}; // 3->0 wrap
    vecs[7]  = '{1'b1, 2'b00, 2'd0, 2'd1, 1'b0, 1'b0, 2'd0, 1'b1};
    vecs[8]  = '{1'b1, 2'b10, 2'd3, 2'd3, 1'b1, 1'b0, 2'd0, 1'b1}; // backward
    vecs[9]  = '{1'b1, 2'b00, 2'd0, 2'd1, 1'b1, 1'b0, 2'd0, 1'b1};
    vecs[10] = '{1'b1, 2'b11, 2'd2, 2'd1, 1'b0, 1'b1, 2'd1, 1'b1}; // illegal 00->11
    vecs[11] = '{1'b1, 2'b11, 2'd2, 2'd1, 1'b0, 1'b0, 2'd1, 1'b1};
    vecs[12] = '{1'b1, 2'b01, 2'd1, 2'd3, 1'b1, 1'b0, 2'd1, 1'b1}; // legal 11->01
    vecs[13] = '{1'b0, 2'b11, 2'd1, 2'd3, 1'b0, 1'b0, 2'd1, 1'b1}; // gated
    vecs[14] = '{1'b0, 2'b10, 2'd1, 2'd3, 1'b0, 1'b0, 2'd1, 1'b1};
    vecs[15] = '{1'b1, 2'b10, 2'd3, 2'd3, 1'b0, 1'b1, 2'd2, 1'b1}; // 01->10 illegal

    rst         = 1'b1;
    bus.en      = 1'b0;
    bus.gray_in = 2'b01;
    #12;
    check_all("reset", 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].en, vecs[i].g);
      check_all($sformatf("v%0d", i), vecs[i].bin, vecs[i].dlt, vecs[i].upd,
                vecs[i].err, vecs[i].cnt, vecs[i].primed);
    end

    // Legal 10->11: bin 3->2, delta (2-3) mod 4 = 3.
    step(1'b1, 2'b11);
    check_all("pre_rst", 2'd2, 2'd3, 1'b1, 1'b0, 2'd2, 1'b1);

    // Asynchronous reset between edges clears outputs without a clock edge.
    #2;
    rst = 1'b1;
    #1;
    check_all("async_rst", 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Re-prime on 11 must not produce upd/err.
    step(1'b1, 2'b11);
    check_all("reprime", 2'd2, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1);

    // Five illegal jumps: counter saturates at 3.
    step(1'b1, 2'b00);
    check_all("sat1", 2'd0, 2'd0, 1'b0, 1'b1, 2'd1, 1'b1);
    step(1'b1, 2'b11);
    check_all("sat2", 2'd2, 2'd0, 1'b0, 1'b1, 2'd2, 1'b1);
    step(1'b1, 2'b00);
    check_all("sat3", 2'd0, 2'd0, 1'b0, 1'b1, 2'd3, 1'b1);
    step(1'b1, 2'b11);
    check_all("sat4", 2'd2, 2'd0, 1'b0, 1'b1, 2'd3, 1'b1);
    step(1'b1, 2'b00);
    check_all("sat5", 2'd0, 2'd0, 1'b0, 1'b1, 2'd3, 1'b1);
    step(1'b1, 2'b00);
    check_all("sat_hold", 2'd0, 2'd0, 1'b0, 1'b0, 2'd3, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
